// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the time-set controller: state/field encoding,
// per-field widths and wrap limits.
package clock_pkg;

  // State doubles as the edit_field encoding; SET_* states are consecutive
  // so "next field" is a plain increment.
  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_HOUR  = 3'd1,
    ST_SET_MIN   = 3'd2,
    ST_SET_SEC   = 3'd3,
    ST_SET_DAY   = 3'd4,
    ST_SET_MONTH = 3'd5,
    ST_COMMIT    = 3'd6
  } state_t;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int TMO_W   = 6;

  localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
  localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
  localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
  localparam logic [DAY_W-1:0]   DAY_MAX   = 5'd29;
  localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd11;

endpackage

// File: rtl/clock_set_ctrl_btn_edge.sv
// Registers a debounced button level and flags its rising edge.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: walks MODE/INC edits through the time fields while
// the timekeeper is frozen, then commits them over a valid/ready load port.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 30,
  parameter bit BLINK_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic [SEC_W-1:0]   cur_sec,
  input  logic [MIN_W-1:0]   cur_min,
  input  logic [HOUR_W-1:0]  cur_hour,
  input  logic [DAY_W-1:0]   cur_day,
  input  logic [MONTH_W-1:0] cur_month,
  output logic               run_en,
  output logic               ld_valid,
  input  logic               ld_ready,
  output logic [SEC_W-1:0]   ld_sec,
  output logic [MIN_W-1:0]   ld_min,
  output logic [HOUR_W-1:0]  ld_hour,
  output logic [DAY_W-1:0]   ld_day,
  output logic [MONTH_W-1:0] ld_month,
  output logic [2:0]         edit_field,
  output logic               blink
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_S - 1);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             mode_edge;
  logic             inc_edge;

  btn_edge u_mode_edge (.clk(clk), .reset(reset), .level(btn_mode), .rise(mode_edge));
  btn_edge u_inc_edge  (.clk(clk), .reset(reset), .level(btn_inc),  .rise(inc_edge));

  // Values outside the legal range also fold back to zero.
  function automatic logic [5:0] inc_wrap(input logic [5:0] val, input logic [5:0] max);
    return (val >= max) ? 6'd0 : val + 6'd1;
  endfunction

  assign edit_field = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      run_en   <= 1'b1;
      ld_valid <= 1'b0;
      ld_sec   <= '0;
      ld_min   <= '0;
      ld_hour  <= '0;
      ld_day   <= '0;
      ld_month <= '0;
      tmo_cnt  <= '0;
      blink    <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (mode_edge) begin
            ld_sec   <= cur_sec;
            ld_min   <= cur_min;
            ld_hour  <= cur_hour;
            ld_day   <= cur_day;
            ld_month <= cur_month;
            state    <= ST_SET_HOUR;
            run_en   <= 1'b0;
            tmo_cnt  <= '0;
            blink    <= 1'b1;
          end
        end

        ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC, ST_SET_DAY, ST_SET_MONTH: begin
          if (mode_edge) begin
            // MODE wins over a coincident INC; SET_MONTH + 1 is COMMIT.
            state   <= state_t'(state + 3'd1);
            tmo_cnt <= '0;
            blink   <= 1'b1;
            if (state == ST_SET_MONTH) ld_valid <= 1'b1;
          end else if (inc_edge) begin
            case (state)
              ST_SET_HOUR:  ld_hour  <= HOUR_W'(inc_wrap(6'(ld_hour), 6'(HOUR_MAX)));
              ST_SET_MIN:   ld_min   <= inc_wrap(ld_min, MIN_MAX);
              ST_SET_SEC:   ld_sec   <= inc_wrap(ld_sec, SEC_MAX);
              ST_SET_DAY:   ld_day   <= DAY_W'(inc_wrap(6'(ld_day), 6'(DAY_MAX)));
              default:      ld_month <= MONTH_W'(inc_wrap(6'(ld_month), 6'(MONTH_MAX)));
            endcase
            tmo_cnt <= '0;
            if (tick_1hz) blink <= BLINK_EN ? ~blink : 1'b1;
          end else if (tick_1hz) begin
            if (tmo_cnt == TMO_LAST) begin
              state   <= ST_RUN;
              run_en  <= 1'b1;
              tmo_cnt <= '0;
              blink   <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
              blink   <= BLINK_EN ? ~blink : 1'b1;
            end
          end
        end

        ST_COMMIT: begin
          if (ld_ready) begin
            ld_valid <= 1'b0;
            state    <= ST_RUN;
            run_en   <= 1'b1;
          end
        end

        default: begin
          state    <= ST_RUN;
          run_en   <= 1'b1;
          ld_valid <= 1'b0;
          blink    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: expectations queued as stimulus is
// applied, then popped and compared against the outputs.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] cur_sec;
  logic [5:0] cur_min;
  logic [4:0] cur_hour;
  logic [4:0] cur_day;
  logic [3:0] cur_month;
  logic       run_en;
  logic       ld_valid;
  logic       ld_ready;
  logic [5:0] ld_sec;
  logic [5:0] ld_min;
  logic [4:0] ld_hour;
  logic [4:0] ld_day;
  logic [3:0] ld_month;
  logic [2:0] edit_field;
  logic       blink;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];

  always #5 clk = ~clk;

  clock_set_ctrl #(.TIMEOUT_S(3), .BLINK_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .cur_day(cur_day), .cur_month(cur_month),
    .run_en(run_en), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
    .ld_day(ld_day), .ld_month(ld_month),
    .edit_field(edit_field), .blink(blink)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (val_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %0d required <queued value>", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0d required %0d", t, obs, e);
      end
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(1);
    btn_mode = 1'b0; cyc(1);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; cyc(1);
    btn_inc = 1'b0; cyc(1);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1; cyc(1);
    tick_1hz = 1'b0; cyc(1);
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; ld_ready = 1'b0;
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56; cur_day = 5'd5; cur_month = 4'd3;

    // Reset state
    sb_push("rst_run_en", 1); sb_push("rst_ld_valid", 0); sb_push("rst_field", 0);
    sb_push("rst_blink", 1);  sb_push("rst_ld_hour", 0);
    cyc(2);
    sb_check(32'(run_en)); sb_check(32'(ld_valid)); sb_check(32'(edit_field));
    sb_check(32'(blink));  sb_check(32'(ld_hour));
    reset = 1'b0;
    cyc(1);

    // Enter edit with hour 23, wrap it, and walk to COMMIT
    cur_hour = 5'd23;
    sb_push("enter_field", 1); sb_push("enter_run_en", 0); sb_push("enter_ld_hour", 23);
    press_mode();
    sb_check(32'(edit_field)); sb_check(32'(run_en)); sb_check(32'(ld_hour));
    sb_push("hour_wrap", 0);
    press_inc();
    sb_check(32'(ld_hour));
    for (int f = 2; f <= 6; f++) begin
      sb_push($sformatf("walk_field_%0d", f), 32'(f));
      press_mode();
      sb_check(32'(edit_field));
    end
    sb_push("commit_valid", 1); sb_push("commit_min", 34); sb_push("commit_sec", 56);
    sb_push("commit_day", 5);   sb_push("commit_month", 3); sb_push("commit_run_en", 0);
    sb_check(32'(ld_valid)); sb_check(32'(ld_min)); sb_check(32'(ld_sec));
    sb_check(32'(ld_day));   sb_check(32'(ld_month)); sb_check(32'(run_en));

    // Held COMMIT: INC press is ignored, data stays stable
    press_inc();
    sb_push("commit_hold_valid", 1); sb_push("commit_hold_hour", 0); sb_push("commit_hold_field", 6);
    sb_check(32'(ld_valid)); sb_check(32'(ld_hour)); sb_check(32'(edit_field));
    ld_ready = 1'b1;
    cyc(1);
    ld_ready = 1'b0;
    sb_push("xfer_valid", 0); sb_push("xfer_run_en", 1); sb_push("xfer_field", 0);
    sb_push("xfer_blink", 1);
    sb_check(32'(ld_valid)); sb_check(32'(run_en)); sb_check(32'(edit_field));
    sb_check(32'(blink));
    cyc(1);

    // Simultaneous MODE+INC, field wraps, held INC
    cur_hour = 5'd7; cur_min = 6'd58; cur_sec = 6'd0; cur_day = 5'd29; cur_month = 4'd11;
    press_mode();
    btn_mode = 1'b1; btn_inc = 1'b1; cyc(1);
    btn_mode = 1'b0; btn_inc = 1'b0; cyc(1);
    sb_push("simul_field", 2); sb_push("simul_hour", 7);
    sb_check(32'(edit_field)); sb_check(32'(ld_hour));
    sb_push("min_59", 59);
    press_inc();
    sb_check(32'(ld_min));
    sb_push("min_wrap", 0);
    press_inc();
    sb_check(32'(ld_min));
    btn_inc = 1'b1; cyc(10);
    btn_inc = 1'b0; cyc(1);
    sb_push("held_inc", 1);
    sb_check(32'(ld_min));
    press_mode(); press_mode();
    sb_push("day_field", 4); sb_push("day_wrap", 0);
    press_inc();
    sb_check(32'(edit_field)); sb_check(32'(ld_day));
    press_mode();
    sb_push("month_wrap", 0);
    press_inc();
    sb_check(32'(ld_month));
    press_mode();
    sb_push("c2_valid", 1); sb_push("c2_hour", 7); sb_push("c2_min", 1);
    sb_check(32'(ld_valid)); sb_check(32'(ld_hour)); sb_check(32'(ld_min));
    ld_ready = 1'b1; cyc(1); ld_ready = 1'b0;
    sb_push("c2_done", 0);
    sb_check(32'(ld_valid));
    cyc(1);

    // Reset mid-edit in SET_MIN aborts with no load
    press_mode(); press_mode();
    sb_push("pre_rst_field", 2);
    sb_check(32'(edit_field));
    reset = 1'b1; cyc(1); reset = 1'b0;
    sb_push("abort_field", 0); sb_push("abort_run_en", 1); sb_push("abort_valid", 0);
    sb_push("abort_ld_min", 0);
    sb_check(32'(edit_field)); sb_check(32'(run_en)); sb_check(32'(ld_valid));
    sb_check(32'(ld_min));
    cyc(1);

    // Timeout after 3 ticks in SET_SEC; blink toggles per tick
    cur_sec = 6'd10;
    press_mode(); press_mode(); press_mode();
    sb_push("sec_field", 3); sb_push("sec_blink_entry", 1);
    sb_check(32'(edit_field)); sb_check(32'(blink));
    pulse_tick();
    sb_push("tick1_blink", 0); sb_push("tick1_field", 3);
    sb_check(32'(blink)); sb_check(32'(edit_field));
    pulse_tick();
    sb_push("tick2_blink", 1);
    sb_check(32'(blink));
    pulse_tick();
    sb_push("tmo_field", 0); sb_push("tmo_run_en", 1); sb_push("tmo_valid", 0);
    sb_check(32'(edit_field)); sb_check(32'(run_en)); sb_check(32'(ld_valid));

    // INC restarts the timeout counter
    press_mode(); press_mode(); press_mode();
    pulse_tick(); pulse_tick();
    press_inc();
    pulse_tick(); pulse_tick();
    sb_push("restart_field", 3); sb_push("restart_sec", 11); sb_push("restart_run_en", 0);
    sb_check(32'(edit_field)); sb_check(32'(ld_sec)); sb_check(32'(run_en));
    pulse_tick();
    sb_push("restart_tmo_field", 0); sb_push("restart_tmo_valid", 0);
    sb_check(32'(edit_field)); sb_check(32'(ld_valid));

    checks++;
    assert (val_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover: observed %0d entries required 0", val_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
